// File: rtl/muldiv_ctrl_pkg.sv
// ============================================================================
// Module  : muldiv_ctrl_pkg
// Brief   : RV32M funct3 codes, FSM state encoding and operand-sign helpers
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_ctrl_pkg;

  localparam logic [2:0] c_MULDIV_MUL    = 3'b000;
  localparam logic [2:0] c_MULDIV_MULH   = 3'b001;
  localparam logic [2:0] c_MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] c_MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] c_MULDIV_DIV    = 3'b100;
  localparam logic [2:0] c_MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] c_MULDIV_REM    = 3'b110;
  localparam logic [2:0] c_MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM
  function automatic logic arg1_signed(input logic [2:0] op);
    return (op == c_MULDIV_MUL) || (op == c_MULDIV_MULH) || (op == c_MULDIV_MULHSU) ||
           (op == c_MULDIV_DIV) || (op == c_MULDIV_REM);
  endfunction

  function automatic logic arg2_signed(input logic [2:0] op);
    return (op == c_MULDIV_MUL) || (op == c_MULDIV_MULH) ||
           (op == c_MULDIV_DIV) || (op == c_MULDIV_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_core.sv
// ============================================================================
// Module  : muldiv_core
// Brief   : one-step shift-add multiply / restoring divide on a 2W accumulator
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH:0]   w_shl;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_nxt;

  // Multiply: {hi,lo} with multiplier in lo; add multiplicand to hi, shift right
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: {rem,quo}; shift left, keep the trial subtraction when it does not borrow
  assign w_shl     = {r_acc, 1'b0};
  assign w_diff    = w_shl[2*WIDTH:WIDTH] - {1'b0, r_b};
  assign w_div_nxt = w_diff[WIDTH] ? w_shl[2*WIDTH-1:0]
                                   : {w_diff[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};

  assign acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
    end else if (load) begin
      r_acc    <= {{WIDTH{1'b0}}, op_a};
      r_b      <= op_b;
      r_is_div <= is_div;
    end else if (step) begin
      r_acc    <= acc_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module  : muldiv_ctrl
// Brief   : iterative RV32M sequencer - FSM, counter, sign fixup, output regs
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WORD_SIZE-1:0] arg1,
  input  logic [WORD_SIZE-1:0] arg2,
  input  logic [REG_SEL-1:0]   rd,
  input  logic                 flush,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic [REG_SEL-1:0]   rd_out
);

  localparam logic [WORD_SIZE-1:0] c_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

  muldiv_state_t r_state, w_state_nxt;
  logic [4:0]           r_count;
  logic [2:0]           r_op;
  logic [REG_SEL-1:0]   r_rd;
  logic                 r_neg;
  logic [WORD_SIZE-1:0] r_fix;

  logic                   w_accept, w_sa, w_sb, w_div0, w_ovf, w_fix, w_neg, w_last;
  logic [WORD_SIZE-1:0]   w_mag1, w_mag2, w_fix_val;
  logic [2*WORD_SIZE-1:0] w_acc_nxt, w_prod;
  logic [WORD_SIZE-1:0]   w_quo_rem, w_div_res, w_final;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_sa     = arg1_signed(op) & arg1[WORD_SIZE-1];
  assign w_sb     = arg2_signed(op) & arg2[WORD_SIZE-1];
  assign w_mag1   = w_sa ? -arg1 : arg1;
  assign w_mag2   = w_sb ? -arg2 : arg2;
  assign w_div0   = (arg2 == '0);
  assign w_ovf    = ((op == c_MULDIV_DIV) || (op == c_MULDIV_REM)) &&
                    (arg1 == c_MIN) && (arg2 == '1);
  assign w_fix    = op[2] && (w_div0 || w_ovf);
  // Remainder takes the dividend's sign; products and quotients take the xor
  assign w_neg    = (op[2] && op[1]) ? w_sa : (w_sa ^ w_sb);
  assign w_fix_val = w_div0 ? (op[1] ? arg1 : '1) : (op[1] ? '0 : c_MIN);

  muldiv_core #(.WIDTH(WORD_SIZE)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (w_accept),
    .step    ((r_state == S_RUN) && !flush),
    .is_div  (op[2]),
    .op_a    (w_mag1),
    .op_b    (w_mag2),
    .acc_nxt (w_acc_nxt)
  );

  // Final result is formed from the last step's value so it is registered on entry to DONE
  assign w_last    = (r_state == S_RUN) && (r_count == 5'd31);
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo_rem = r_op[1] ? w_acc_nxt[2*WORD_SIZE-1:WORD_SIZE] : w_acc_nxt[WORD_SIZE-1:0];
  assign w_div_res = r_neg ? -w_quo_rem : w_quo_rem;
  assign w_final   = r_op[2] ? w_div_res :
                     (r_op == c_MULDIV_MUL) ? w_prod[WORD_SIZE-1:0]
                                            : w_prod[2*WORD_SIZE-1:WORD_SIZE];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_fix ? S_FIX : S_RUN;
      S_RUN:   if (r_count == 5'd31) w_state_nxt = S_DONE;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_neg   <= 1'b0;
      r_fix   <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= ((r_state == S_RUN) && !flush) ? r_count + 5'd1 : 5'd0;
      if (w_accept) begin
        r_op  <= op;
        r_rd  <= rd;
        r_neg <= w_neg;
        r_fix <= w_fix_val;
      end
      if (!flush && w_last) begin
        result <= w_final;
        rd_out <= r_rd;
      end else if (!flush && (r_state == S_FIX)) begin
        result <= r_fix;
        rd_out <= r_rd;
      end
    end
  end

  assign stall = w_accept || (r_state == S_RUN) || (r_state == S_FIX);
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE) && !flush;

endmodule

`default_nettype wire
